// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard / flow controller for a 5-stage in-order core.
//   Decides each cycle whether the PC, IF/ID and ID/EX registers advance,
//   which flushes/bubbles are applied, and where the next PC comes from.
//   Three registered modes: normal run, draining after a trap, and waiting
//   on a multi-cycle mul/div unit. All control outputs are combinational
//   from the current mode and the inputs.
//
// Parameters
//   TRAP_DRAIN   extra flush cycles after a trap is taken (1..7)
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   id_rs1, id_rs2        source registers of the instruction in ID
//   ex_rd, ex_mem_read    destination register / load flag of the insn in EX
//   branch_taken          EX resolved a taken branch or jalr
//   id_jal                JAL decoded in ID
//   trap_req              exception or interrupt request
//   imem_ready            fetch data valid
//   md_start, md_done     multi-cycle mul/div issue / completion
//   pc_write, IFID_write, IDEX_write        register enables
//   flush_trap, flush_jal, flush_branch     IF/ID flush sources
//   idex_bubble           insert NOP into ID/EX
//   pc_sel                00 PC+4, 01 EX target, 10 ID JAL target, 11 trap vec
//   trap_ack              one-cycle acknowledge when a trap is taken
//   md_abort              mul/div operation abandoned because of a trap
//   stall_cycles          saturating count of stall cycles
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned TRAP_DRAIN = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        branch_taken,
    input  logic        id_jal,
    input  logic        trap_req,
    input  logic        imem_ready,
    input  logic        md_start,
    input  logic        md_done,
    output logic        pc_write,
    output logic        IFID_write,
    output logic        IDEX_write,
    output logic        flush_trap,
    output logic        flush_jal,
    output logic        flush_branch,
    output logic        idex_bubble,
    output logic [1:0]  pc_sel,
    output logic        trap_ack,
    output logic        md_abort,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_TRAP_FLUSH = 2'd1,
        ST_MD_WAIT    = 2'd2
    } state_e;

    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_EX   = 2'b01;
    localparam logic [1:0] PC_JAL  = 2'b10;
    localparam logic [1:0] PC_TRAP = 2'b11;

    localparam logic [2:0] DRAIN_INIT = 3'(TRAP_DRAIN);

    state_e      state_q, state_d;
    logic [2:0]  drain_q, drain_d;
    logic [31:0] stall_q, stall_d;

    logic load_use;
    logic stall_inc;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        drain_d      = drain_q;
        pc_write     = 1'b1;
        IFID_write   = 1'b1;
        IDEX_write   = 1'b1;
        flush_trap   = 1'b0;
        flush_jal    = 1'b0;
        flush_branch = 1'b0;
        idex_bubble  = 1'b0;
        pc_sel       = PC_SEQ;
        trap_ack     = 1'b0;
        md_abort     = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (trap_req) begin
                    flush_trap  = 1'b1;
                    idex_bubble = 1'b1;
                    pc_sel      = PC_TRAP;
                    trap_ack    = 1'b1;
                    drain_d     = DRAIN_INIT;
                    state_d     = ST_TRAP_FLUSH;
                end else if (branch_taken) begin
                    // A JAL in ID this cycle is on the wrong path; drop it.
                    flush_branch = 1'b1;
                    idex_bubble  = 1'b1;
                    pc_sel       = PC_EX;
                end else if (id_jal) begin
                    // Only the fall-through fetch is squashed; JAL moves on.
                    flush_jal = 1'b1;
                    pc_sel    = PC_JAL;
                end else if (md_start) begin
                    pc_write   = 1'b0;
                    IFID_write = 1'b0;
                    IDEX_write = 1'b0;
                    state_d    = ST_MD_WAIT;
                end else if (load_use || !imem_ready) begin
                    pc_write    = 1'b0;
                    IFID_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            end

            ST_TRAP_FLUSH: begin
                // New traps are not accepted until the drain completes.
                flush_trap  = 1'b1;
                idex_bubble = 1'b1;
                pc_write    = 1'b0;
                drain_d     = drain_q - 3'd1;
                // <= guards against a stuck drain should the count ever be 0.
                if (drain_q <= 3'd1) begin
                    state_d = ST_RUN;
                end
            end

            ST_MD_WAIT: begin
                if (trap_req) begin
                    // Trap wins over a completing mul/div; the result is lost.
                    md_abort    = 1'b1;
                    flush_trap  = 1'b1;
                    idex_bubble = 1'b1;
                    pc_sel      = PC_TRAP;
                    trap_ack    = 1'b1;
                    drain_d     = DRAIN_INIT;
                    state_d     = ST_TRAP_FLUSH;
                end else if (md_done) begin
                    state_d = ST_RUN;
                end else begin
                    pc_write   = 1'b0;
                    IFID_write = 1'b0;
                    IDEX_write = 1'b0;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        // The pipeline must stay frozen and clean for as long as reset is high.
        if (reset) begin
            pc_write     = 1'b0;
            IFID_write   = 1'b0;
            IDEX_write   = 1'b0;
            flush_trap   = 1'b0;
            flush_jal    = 1'b0;
            flush_branch = 1'b0;
            idex_bubble  = 1'b0;
            pc_sel       = PC_SEQ;
            trap_ack     = 1'b0;
            md_abort     = 1'b0;
        end
    end

    // A stall is a cycle where fetch is held and nothing is being flushed.
    assign stall_inc = !IFID_write && !(flush_trap || flush_jal || flush_branch);

    always_comb begin
        stall_d = stall_q;
        if (stall_inc && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            drain_q <= 3'd0;
            stall_q <= 32'd0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Self-checking bench for hazard_ctrl: a table of single-cycle vectors in
//   the run state, hand-written multi-cycle sequences (trap drain, mul/div
//   wait, trap abort, reset mid-sequence) and a randomized phase compared
//   against a rule-level reference model.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int DRAIN = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_mem_read, branch_taken, id_jal, trap_req;
    logic        imem_ready, md_start, md_done;
    logic        pc_write, IFID_write, IDEX_write;
    logic        flush_trap, flush_jal, flush_branch, idex_bubble;
    logic [1:0]  pc_sel;
    logic        trap_ack, md_abort;
    logic [31:0] stall_cycles;

    hazard_ctrl #(.TRAP_DRAIN(DRAIN)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .branch_taken (branch_taken),
        .id_jal       (id_jal),
        .trap_req     (trap_req),
        .imem_ready   (imem_ready),
        .md_start     (md_start),
        .md_done      (md_done),
        .pc_write     (pc_write),
        .IFID_write   (IFID_write),
        .IDEX_write   (IDEX_write),
        .flush_trap   (flush_trap),
        .flush_jal    (flush_jal),
        .flush_branch (flush_branch),
        .idex_bubble  (idex_bubble),
        .pc_sel       (pc_sel),
        .trap_ack     (trap_ack),
        .md_abort     (md_abort),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic mr, br, jal, trap, imr, mds, mdd;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [10:0] exp;
        bit         inc;
        string      name;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Reference model state: flush cycles still owed after a trap, whether a
    // mul/div is outstanding, and the expected stall count.
    int          flush_left = 0;
    bit          md_wait = 1'b0;
    logic [31:0] m_stall = 32'd0;

    // Output vector: {pc_write, IFID, IDEX, f_trap, f_jal, f_branch, bubble,
    //                 pc_sel[1:0], trap_ack, md_abort}
    function automatic logic [10:0] mk(input bit pcw, ifw, idw, ft, fj, fb, bub,
                                       input logic [1:0] sel, input bit ack, ab);
        return {pcw, ifw, idw, ft, fj, fb, bub, sel, ack, ab};
    endfunction

    function automatic stim_t mk_s(input logic [4:0] rs1, rs2, rd,
                                   input bit mr, br, jal, trap, imr, mds, mdd);
        stim_t s;
        s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
        s.mr = mr; s.br = br; s.jal = jal; s.trap = trap;
        s.imr = imr; s.mds = mds; s.mdd = mdd;
        return s;
    endfunction

    function automatic logic [10:0] pack_dut();
        return {pc_write, IFID_write, IDEX_write, flush_trap, flush_jal,
                flush_branch, idex_bubble, pc_sel, trap_ack, md_abort};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input stim_t s);
        id_rs1 = s.rs1; id_rs2 = s.rs2; ex_rd = s.rd;
        ex_mem_read = s.mr; branch_taken = s.br; id_jal = s.jal;
        trap_req = s.trap; imem_ready = s.imr; md_start = s.mds; md_done = s.mdd;
    endtask

    // Expected outputs from the behavioural rules, plus the next model state.
    function automatic void model_eval(input stim_t s, output logic [10:0] o,
                                       output bit inc, output int n_left, output bit n_md);
        bit pcw = 1, ifw = 1, idw = 1, ft = 0, fj = 0, fb = 0, bub = 0, ack = 0, ab = 0;
        logic [1:0] sel = 2'b00;
        n_left = 0;
        n_md   = 1'b0;
        if (flush_left > 0) begin
            ft = 1; bub = 1; pcw = 0;
            n_left = flush_left - 1;
        end else if (md_wait && s.trap) begin
            ab = 1; ft = 1; bub = 1; sel = 2'b11; ack = 1;
            n_left = DRAIN;
        end else if (md_wait && !s.mdd) begin
            pcw = 0; ifw = 0; idw = 0;
            n_md = 1'b1;
        end else if (md_wait) begin
            // result arrived: everything at defaults
        end else if (s.trap) begin
            ft = 1; bub = 1; sel = 2'b11; ack = 1;
            n_left = DRAIN;
        end else if (s.br) begin
            fb = 1; bub = 1; sel = 2'b01;
        end else if (s.jal) begin
            fj = 1; sel = 2'b10;
        end else if (s.mds) begin
            pcw = 0; ifw = 0; idw = 0;
            n_md = 1'b1;
        end else if ((s.mr && s.rd != 0 && (s.rd == s.rs1 || s.rd == s.rs2)) || !s.imr) begin
            pcw = 0; ifw = 0; bub = 1;
        end
        o   = {pcw, ifw, idw, ft, fj, fb, bub, sel, ack, ab};
        inc = !ifw && !(ft || fj || fb);
    endfunction

    // One clock cycle: drive after the falling edge, compare combinational
    // outputs, then compare the stall count just after the rising edge.
    task automatic step(input stim_t s, input logic [10:0] hand_exp,
                        input bit use_hand, input string name);
        logic [10:0] m_exp;
        bit          m_inc;
        int          n_left;
        bit          n_md;
        @(negedge clk);
        drive(s);
        #1;
        model_eval(s, m_exp, m_inc, n_left, n_md);
        check(name, 32'(pack_dut()), 32'(use_hand ? hand_exp : m_exp));
        @(posedge clk);
        flush_left = n_left;
        md_wait    = n_md;
        if (m_inc && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
        #1;
        check({name, "/stall"}, stall_cycles, m_stall);
    endtask

    task automatic pulse_reset(input int cycles, input string name);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check({name, "/outs_in_reset"}, 32'(pack_dut()), 32'd0);
        check({name, "/stall_in_reset"}, stall_cycles, 32'd0);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        drive(mk_s(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        #1;
        check({name, "/outs_late_reset"}, 32'(pack_dut()), 32'd0);
        reset      = 1'b0;
        flush_left = 0;
        md_wait    = 1'b0;
        m_stall    = 32'd0;
    endtask

    localparam logic [10:0] DEF    = 11'b111_0000_00_00;
    localparam logic [10:0] LU     = 11'b001_0001_00_00;
    localparam logic [10:0] BR     = 11'b111_0011_01_00;
    localparam logic [10:0] JAL    = 11'b111_0100_10_00;
    localparam logic [10:0] TRAP   = 11'b111_1001_11_10;
    localparam logic [10:0] TFL    = 11'b011_1001_00_00;
    localparam logic [10:0] MDS    = 11'b000_0000_00_00;
    localparam logic [10:0] MDTRAP = 11'b111_1001_11_11;

    initial begin
        vec_t  tbl[14];
        stim_t idle;
        stim_t rs;
        logic [31:0] hand_stall;

        idle = mk_s(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        drive(idle);

        // Sanity-check the hand constants against the field builder.
        check("const/def",  32'(DEF),  32'(mk(1,1,1,0,0,0,0,2'b00,0,0)));
        check("const/trap", 32'(TRAP), 32'(mk(1,1,1,1,0,0,1,2'b11,1,0)));

        pulse_reset(2, "por");

        // ---------------- table-driven single-cycle vectors ----------------
        //                  rs1 rs2 rd mr br jal trap imr mds mdd
        tbl[0]  = '{mk_s(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), DEF, 1'b0, "idle"};
        tbl[1]  = '{mk_s(1, 5, 5, 1, 0, 0, 0, 1, 0, 0), LU,  1'b1, "lu_rs2"};
        tbl[2]  = '{mk_s(1, 5, 5, 0, 0, 0, 0, 1, 0, 0), DEF, 1'b0, "lu_release"};
        tbl[3]  = '{mk_s(0, 2, 0, 1, 0, 0, 0, 1, 0, 0), DEF, 1'b0, "lu_x0"};
        tbl[4]  = '{mk_s(7, 1, 7, 0, 0, 0, 0, 1, 0, 0), DEF, 1'b0, "match_no_load"};
        tbl[5]  = '{mk_s(3, 9, 3, 1, 0, 0, 0, 1, 0, 0), LU,  1'b1, "lu_rs1"};
        tbl[6]  = '{mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), LU,  1'b1, "imem_wait"};
        tbl[7]  = '{mk_s(0, 0, 0, 0, 1, 0, 0, 1, 0, 0), BR,  1'b0, "branch"};
        tbl[8]  = '{mk_s(0, 0, 0, 0, 1, 1, 0, 1, 0, 0), BR,  1'b0, "branch_and_jal"};
        tbl[9]  = '{mk_s(0, 0, 0, 0, 0, 1, 0, 1, 0, 0), JAL, 1'b0, "jal"};
        tbl[10] = '{mk_s(4, 0, 4, 1, 0, 1, 0, 1, 0, 0), JAL, 1'b0, "jal_over_lu"};
        tbl[11] = '{mk_s(0, 0, 0, 0, 1, 0, 0, 0, 0, 0), BR,  1'b0, "branch_over_imem"};
        tbl[12] = '{mk_s(0, 0, 0, 0, 0, 1, 0, 0, 0, 0), JAL, 1'b0, "jal_over_imem"};
        tbl[13] = '{mk_s(6, 6, 6, 1, 0, 0, 0, 0, 0, 0), LU,  1'b1, "lu_and_imem"};

        hand_stall = 32'd0;
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].s, tbl[i].exp, 1'b1, tbl[i].name);
            if (tbl[i].inc) hand_stall = hand_stall + 32'd1;
            check({tbl[i].name, "/hand_stall"}, stall_cycles, hand_stall);
        end

        // ---------------- trap drain, second trap ignored ----------------
        step(mk_s(0, 0, 0, 0, 0, 0, 1, 1, 0, 0), TRAP, 1'b1, "trap/take");
        step(mk_s(0, 0, 0, 0, 0, 0, 1, 1, 0, 0), TFL,  1'b1, "trap/drain1_retrap");
        step(idle,                                TFL,  1'b1, "trap/drain2");
        step(idle,                                DEF,  1'b1, "trap/back_to_run");

        // ---------------- simultaneous events ----------------
        step(mk_s(0, 0, 0, 0, 1, 1, 0, 1, 0, 0), BR,   1'b1, "simul/br_jal");
        step(mk_s(0, 0, 0, 0, 1, 1, 1, 1, 1, 0), TRAP, 1'b1, "simul/trap_wins");
        step(idle,                                TFL,  1'b1, "simul/drain1");
        step(idle,                                TFL,  1'b1, "simul/drain2");
        step(mk_s(0, 0, 0, 0, 1, 0, 0, 1, 1, 0), BR,   1'b1, "simul/br_over_md");
        step(idle,                                DEF,  1'b1, "simul/no_md_wait");

        // ---------------- mul/div wait from a clean count ----------------
        pulse_reset(1, "md_rst");
        step(mk_s(2, 2, 2, 1, 0, 0, 0, 0, 1, 0), MDS, 1'b1, "md/start_over_lu");
        for (int i = 0; i < 4; i++) step(idle, MDS, 1'b1, "md/wait");
        step(mk_s(0, 0, 0, 0, 0, 0, 0, 1, 0, 1), DEF, 1'b1, "md/done");
        check("md/stall_total", stall_cycles, 32'd5);

        // ---------------- mul/div aborted by trap ----------------
        step(mk_s(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), MDS,    1'b1, "mdtrap/start");
        step(idle,                                MDS,    1'b1, "mdtrap/wait1");
        step(mk_s(0, 0, 0, 0, 1, 1, 0, 0, 0, 0), MDS,    1'b1, "mdtrap/wait_ignores_run_events");
        step(mk_s(0, 0, 0, 0, 0, 0, 1, 1, 0, 1), MDTRAP, 1'b1, "mdtrap/abort");
        step(idle,                                TFL,    1'b1, "mdtrap/drain1");
        step(idle,                                TFL,    1'b1, "mdtrap/drain2");
        step(idle,                                DEF,    1'b1, "mdtrap/run");
        check("mdtrap/stall_total", stall_cycles, 32'd8);

        // ---------------- reset mid-sequence ----------------
        step(mk_s(0, 0, 0, 0, 0, 0, 1, 1, 0, 0), TRAP, 1'b1, "rst_tf/trap");
        step(idle,                                TFL,  1'b1, "rst_tf/drain1");
        pulse_reset(2, "rst_tf");
        step(idle, DEF, 1'b1, "rst_tf/after");
        check("rst_tf/stall_zero", stall_cycles, 32'd0);

        step(mk_s(0, 0, 0, 0, 0, 0, 0, 1, 1, 0), MDS, 1'b1, "rst_md/start");
        step(idle,                                MDS, 1'b1, "rst_md/wait");
        pulse_reset(1, "rst_md");
        step(idle, DEF, 1'b1, "rst_md/after");
        check("rst_md/stall_zero", stall_cycles, 32'd0);

        // ---------------- randomized phase against the model ----------------
        for (int i = 0; i < 600; i++) begin
            rs.rs1  = 5'($urandom_range(0, 3));
            rs.rs2  = 5'($urandom_range(0, 3));
            rs.rd   = 5'($urandom_range(0, 3));
            rs.mr   = ($urandom_range(0, 1) == 1);
            rs.br   = ($urandom_range(0, 5) == 0);
            rs.jal  = ($urandom_range(0, 5) == 0);
            rs.trap = ($urandom_range(0, 15) == 0);
            rs.imr  = ($urandom_range(0, 3) != 0);
            rs.mds  = ($urandom_range(0, 7) == 0);
            rs.mdd  = ($urandom_range(0, 3) == 0);
            step(rs, 11'd0, 1'b0, "rand");
            if (i % 200 == 199) pulse_reset(1, "rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
